// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU op encodings,
// FSM state and trap cause encodings.
package cpu_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_ILLEGAL  = 2'd1,
        CAUSE_FETCH_TO = 2'd2,
        CAUSE_DATA_TO  = 2'd3
    } cause_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port between controller (master) and memory (slave);
// mem_req is held with stable iord/mem_we until mem_ready.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-request cycles; expired is high once the count reaches TIMEOUT.
// Zero latency on expired (registered count, combinational compare); TIMEOUT=0 never expires.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic busy,
    output logic expired
);
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt;

    // Saturates at LIMIT so expired stays asserted until the FSM leaves the wait state.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (busy && (TIMEOUT > 0) && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT > 0) && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM sharing one memory port between fetch and data access.
// BEQ 3, R/I/SW 4, LW 5 cycles with zero-wait memory; each mem_ready stall adds one cycle.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    multicycle_ctrl_if.master   bus,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    retired,
    output logic [2:0]          state
);
    localparam logic [OPCODE_W-1:0] R_OP   = OPCODE_W'(OP_R);
    localparam logic [OPCODE_W-1:0] I_OP   = OPCODE_W'(OP_I);
    localparam logic [OPCODE_W-1:0] LW_OP  = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] SW_OP  = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] BEQ_OP = OPCODE_W'(OP_BEQ);

    state_t              cur;
    logic [OPCODE_W-1:0] opc_q;
    logic                expired;
    logic                legal;
    logic                is_r, is_i, is_lw, is_sw, is_beq;
    logic                req, we, addr_sel;
    logic                timer_clear;

    assign legal  = (opcode == R_OP) || (opcode == I_OP) || (opcode == LW_OP) ||
                    (opcode == SW_OP) || (opcode == BEQ_OP);
    assign is_r   = (opc_q == R_OP);
    assign is_i   = (opc_q == I_OP);
    assign is_lw  = (opc_q == LW_OP);
    assign is_sw  = (opc_q == SW_OP);
    assign is_beq = (opc_q == BEQ_OP);

    assign bus.mem_req = req;
    assign bus.mem_we  = we;
    assign bus.iord    = addr_sel;
    assign state       = cur;

    // The counter only runs while waiting in FETCH/MEM; any completion restarts it.
    assign timer_clear = !((cur == FETCH) || (cur == MEM)) || bus.mem_ready;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .busy   (req && !bus.mem_ready),
        .expired(expired)
    );

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        req        = 1'b0;
        we         = 1'b0;
        addr_sel   = 1'b0;
        if (!reset) begin
            case (cur)
                FETCH: begin
                    req = 1'b1;
                    // A completion on the expiring cycle is dropped in favour of the trap.
                    if (bus.mem_ready && !expired) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                EXEC: begin
                    if (is_lw || is_sw) begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                    end else if (is_r) begin
                        alu_op  = ALU_FUNCT;
                    end else if (is_i) begin
                        alu_op  = ALU_FUNCT;
                        alu_src = 1'b1;
                    end else if (is_beq) begin
                        alu_op = ALU_SUB;
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                    end
                end
                MEM: begin
                    req      = 1'b1;
                    addr_sel = 1'b1;
                    we       = is_sw;
                end
                WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_lw;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= FETCH;
            opc_q      <= '0;
            retired    <= '0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            case (cur)
                FETCH: begin
                    if (expired) begin
                        cur        <= TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_FETCH_TO;
                    end else if (bus.mem_ready) begin
                        cur <= DECODE;
                    end
                end
                DECODE: begin
                    opc_q <= opcode;
                    if (legal) begin
                        cur <= EXEC;
                    end else begin
                        cur        <= TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                    end
                end
                EXEC: begin
                    if (is_beq) begin
                        cur     <= FETCH;
                        retired <= retired + 1'b1;
                    end else if (is_lw || is_sw) begin
                        cur <= MEM;
                    end else begin
                        cur <= WB;
                    end
                end
                MEM: begin
                    if (expired) begin
                        cur        <= TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_DATA_TO;
                    end else if (bus.mem_ready) begin
                        if (is_sw) begin
                            cur     <= FETCH;
                            retired <= retired + 1'b1;
                        end else begin
                            cur <= WB;
                        end
                    end
                end
                WB: begin
                    cur     <= FETCH;
                    retired <= retired + 1'b1;
                end
                TRAP: cur <= TRAP;
                default: cur <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl built with TIMEOUT=3 and CNT_W=4.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    // Strobe vector order: ir_write pc_write pc_src iord alu_src alu_op[1:0] mem_req mem_we mem_to_reg reg_write
    localparam logic [10:0] S_IDLE   = 11'b0_0_0_0_0_00_0_0_0_0;
    localparam logic [10:0] S_FWAIT  = 11'b0_0_0_0_0_00_1_0_0_0;
    localparam logic [10:0] S_FDONE  = 11'b1_1_0_0_0_00_1_0_0_0;
    localparam logic [10:0] S_EX_R   = 11'b0_0_0_0_0_10_0_0_0_0;
    localparam logic [10:0] S_EX_I   = 11'b0_0_0_0_1_10_0_0_0_0;
    localparam logic [10:0] S_EX_LS  = 11'b0_0_0_0_1_00_0_0_0_0;
    localparam logic [10:0] S_EX_BT  = 11'b0_1_1_0_0_01_0_0_0_0;
    localparam logic [10:0] S_EX_BN  = 11'b0_0_0_0_0_01_0_0_0_0;
    localparam logic [10:0] S_MEM_LW = 11'b0_0_0_1_0_00_1_0_0_0;
    localparam logic [10:0] S_MEM_SW = 11'b0_0_0_1_0_00_1_1_0_0;
    localparam logic [10:0] S_WB_ALU = 11'b0_0_0_0_0_00_0_0_0_1;
    localparam logic [10:0] S_WB_LW  = 11'b0_0_0_0_0_00_0_0_1_1;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       ir_write, pc_write, pc_src, alu_src, mem_to_reg, reg_write, trap;
    logic [1:0] alu_op, trap_cause;
    logic [3:0] retired;
    logic [2:0] state;
    int         n_checks;
    int         n_fail;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .OPCODE_W(7),
        .CNT_W   (4),
        .TIMEOUT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .bus       (bus),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .mem_to_reg(mem_to_reg),
        .reg_write (reg_write),
        .trap      (trap),
        .trap_cause(trap_cause),
        .retired   (retired),
        .state     (state)
    );

    wire [10:0] strb = {ir_write, pc_write, pc_src, bus.iord, alu_src, alu_op,
                        bus.mem_req, bus.mem_we, mem_to_reg, reg_write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        opcode = 7'd0;
        zero = 1'b0;
        bus.mem_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks += 5;
        if (strb !== S_IDLE) begin n_fail++; $display("FAIL reset_strobes: got %b expected %b", strb, S_IDLE); end
        if (state !== FETCH) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, FETCH); end
        if (retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b expected 0", trap); end
        if (trap_cause !== 2'd0) begin n_fail++; $display("FAIL reset_cause: got %0d expected 0", trap_cause); end
        next_cycle();
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (state !== FETCH) begin n_fail++; $display("FAIL first_fetch_state: got %0d expected %0d", state, FETCH); end
        if (strb !== S_FWAIT) begin n_fail++; $display("FAIL first_fetch_req: got %b expected %b", strb, S_FWAIT); end
    endtask

    task automatic test_alu();
        logic [6:0]  op [9];
        logic        rdy [9];
        logic [2:0]  st [9];
        logic [10:0] sv [9];
        op  = '{OP_R, OP_R, OP_R, OP_R, OP_I, OP_I, OP_I, OP_I, OP_I};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        st  = '{FETCH, DECODE, EXEC, WB, FETCH, DECODE, EXEC, WB, FETCH};
        sv  = '{S_FDONE, S_IDLE, S_EX_R, S_WB_ALU, S_FDONE, S_IDLE, S_EX_I, S_WB_ALU, S_FWAIT};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            opcode = op[i];
            bus.mem_ready = rdy[i];
            @(negedge clk);
            n_checks += 2;
            if (state !== st[i]) begin n_fail++; $display("FAIL alu_state cyc%0d: got %0d expected %0d", i, state, st[i]); end
            if (strb !== sv[i]) begin n_fail++; $display("FAIL alu_strobes cyc%0d: got %b expected %b", i, strb, sv[i]); end
            if (i == 4 || i == 8) begin
                n_checks++;
                if (retired !== 4'(i / 4)) begin n_fail++; $display("FAIL alu_retired cyc%0d: got %0d expected %0d", i, retired, i / 4); end
            end
            next_cycle();
        end
    endtask

    task automatic test_lw_wait();
        logic        rdy [8];
        logic [2:0]  st [8];
        logic [10:0] sv [8];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        st  = '{FETCH, DECODE, EXEC, MEM, MEM, MEM, WB, FETCH};
        sv  = '{S_FDONE, S_IDLE, S_EX_LS, S_MEM_LW, S_MEM_LW, S_MEM_LW, S_WB_LW, S_FWAIT};
        do_reset();
        opcode = OP_LW;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = rdy[i];
            @(negedge clk);
            n_checks += 2;
            if (state !== st[i]) begin n_fail++; $display("FAIL lw_state cyc%0d: got %0d expected %0d", i, state, st[i]); end
            if (strb !== sv[i]) begin n_fail++; $display("FAIL lw_strobes cyc%0d: got %b expected %b", i, strb, sv[i]); end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (retired !== 4'd1) begin n_fail++; $display("FAIL lw_retired: got %0d expected 1", retired); end
        next_cycle();
    endtask

    task automatic test_beq();
        logic        z [7];
        logic        rdy [7];
        logic [2:0]  st [7];
        logic [10:0] sv [7];
        z   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        st  = '{FETCH, DECODE, EXEC, FETCH, DECODE, EXEC, FETCH};
        sv  = '{S_FDONE, S_IDLE, S_EX_BT, S_FDONE, S_IDLE, S_EX_BN, S_FWAIT};
        do_reset();
        opcode = OP_BEQ;
        for (int i = 0; i < 7; i++) begin
            zero = z[i];
            bus.mem_ready = rdy[i];
            @(negedge clk);
            n_checks += 2;
            if (state !== st[i]) begin n_fail++; $display("FAIL beq_state cyc%0d: got %0d expected %0d", i, state, st[i]); end
            if (strb !== sv[i]) begin n_fail++; $display("FAIL beq_strobes cyc%0d: got %b expected %b", i, strb, sv[i]); end
            if (i == 3 || i == 6) begin
                n_checks++;
                if (retired !== 4'(i / 3)) begin n_fail++; $display("FAIL beq_retired cyc%0d: got %0d expected %0d", i, retired, i / 3); end
            end
            next_cycle();
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        logic [6:0]  op [10];
        logic        rdy [10];
        logic [2:0]  st [10];
        logic [10:0] sv [10];
        op  = '{OP_R, OP_R, OP_R, OP_R, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        st  = '{FETCH, DECODE, EXEC, WB, FETCH, DECODE, TRAP, TRAP, TRAP, TRAP};
        sv  = '{S_FDONE, S_IDLE, S_EX_R, S_WB_ALU, S_FDONE, S_IDLE, S_IDLE, S_IDLE, S_IDLE, S_IDLE};
        do_reset();
        zero = 1'b1;
        for (int i = 0; i < 10; i++) begin
            opcode = op[i];
            bus.mem_ready = rdy[i];
            @(negedge clk);
            n_checks += 2;
            if (state !== st[i]) begin n_fail++; $display("FAIL ill_state cyc%0d: got %0d expected %0d", i, state, st[i]); end
            if (strb !== sv[i]) begin n_fail++; $display("FAIL ill_strobes cyc%0d: got %b expected %b", i, strb, sv[i]); end
            if (i >= 6) begin
                n_checks += 3;
                if (trap !== 1'b1) begin n_fail++; $display("FAIL ill_trap cyc%0d: got %b expected 1", i, trap); end
                if (trap_cause !== 2'd1) begin n_fail++; $display("FAIL ill_cause cyc%0d: got %0d expected 1", i, trap_cause); end
                if (retired !== 4'd1) begin n_fail++; $display("FAIL ill_retired cyc%0d: got %0d expected 1", i, retired); end
            end
            next_cycle();
        end
        zero = 1'b0;
        do_reset();
        @(negedge clk);
        n_checks += 4;
        if (state !== FETCH) begin n_fail++; $display("FAIL ill_reset_state: got %0d expected %0d", state, FETCH); end
        if (trap !== 1'b0) begin n_fail++; $display("FAIL ill_reset_trap: got %b expected 0", trap); end
        if (trap_cause !== 2'd0) begin n_fail++; $display("FAIL ill_reset_cause: got %0d expected 0", trap_cause); end
        if (retired !== 4'd0) begin n_fail++; $display("FAIL ill_reset_retired: got %0d expected 0", retired); end
        next_cycle();
    endtask

    task automatic test_fetch_timeout();
        logic        rdy_a [5];
        logic [2:0]  st_a [5];
        logic [10:0] sv_a [5];
        logic        rdy_b [4];
        logic [2:0]  st_b [4];
        logic [10:0] sv_b [4];
        // Completion on wait cycle 3 (== TIMEOUT) must be ignored.
        rdy_a = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        st_a  = '{FETCH, FETCH, FETCH, FETCH, TRAP};
        sv_a  = '{S_FWAIT, S_FWAIT, S_FWAIT, S_FWAIT, S_IDLE};
        rdy_b = '{1'b0, 1'b0, 1'b1, 1'b0};
        st_b  = '{FETCH, FETCH, FETCH, DECODE};
        sv_b  = '{S_FWAIT, S_FWAIT, S_FDONE, S_IDLE};
        opcode = OP_R;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = rdy_a[i];
            @(negedge clk);
            n_checks += 2;
            if (state !== st_a[i]) begin n_fail++; $display("FAIL fto_state cyc%0d: got %0d expected %0d", i, state, st_a[i]); end
            if (strb !== sv_a[i]) begin n_fail++; $display("FAIL fto_strobes cyc%0d: got %b expected %b", i, strb, sv_a[i]); end
            next_cycle();
        end
        @(negedge clk);
        n_checks += 2;
        if (trap !== 1'b1) begin n_fail++; $display("FAIL fto_trap: got %b expected 1", trap); end
        if (trap_cause !== 2'd2) begin n_fail++; $display("FAIL fto_cause: got %0d expected 2", trap_cause); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = rdy_b[i];
            @(negedge clk);
            n_checks += 2;
            if (state !== st_b[i]) begin n_fail++; $display("FAIL fok_state cyc%0d: got %0d expected %0d", i, state, st_b[i]); end
            if (strb !== sv_b[i]) begin n_fail++; $display("FAIL fok_strobes cyc%0d: got %b expected %b", i, strb, sv_b[i]); end
            next_cycle();
        end
    endtask

    task automatic test_mem_timeout();
        logic [2:0]  st [8];
        logic [10:0] sv [8];
        st = '{FETCH, DECODE, EXEC, MEM, MEM, MEM, MEM, TRAP};
        sv = '{S_FDONE, S_IDLE, S_EX_LS, S_MEM_SW, S_MEM_SW, S_MEM_SW, S_MEM_SW, S_IDLE};
        opcode = OP_SW;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = (i == 0);
            @(negedge clk);
            n_checks += 2;
            if (state !== st[i]) begin n_fail++; $display("FAIL dto_state cyc%0d: got %0d expected %0d", i, state, st[i]); end
            if (strb !== sv[i]) begin n_fail++; $display("FAIL dto_strobes cyc%0d: got %b expected %b", i, strb, sv[i]); end
            next_cycle();
        end
        @(negedge clk);
        n_checks += 2;
        if (trap_cause !== 2'd3) begin n_fail++; $display("FAIL dto_cause: got %0d expected 3", trap_cause); end
        if (retired !== 4'd0) begin n_fail++; $display("FAIL dto_retired: got %0d expected 0", retired); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  st [4];
        logic [10:0] sv [4];
        st = '{FETCH, DECODE, EXEC, MEM};
        sv = '{S_FDONE, S_IDLE, S_EX_LS, S_MEM_SW};
        opcode = OP_SW;
        do_reset();
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                n_checks += 2;
                if (state !== st[j]) begin n_fail++; $display("FAIL sw_state ins%0d cyc%0d: got %0d expected %0d", k, j, state, st[j]); end
                if (strb !== sv[j]) begin n_fail++; $display("FAIL sw_strobes ins%0d cyc%0d: got %b expected %b", k, j, strb, sv[j]); end
                if (j == 0) begin
                    n_checks++;
                    if (retired !== 4'(k)) begin n_fail++; $display("FAIL sw_retired ins%0d: got %0d expected %0d", k, retired, 4'(k)); end
                end
                next_cycle();
            end
        end
        for (int j = 0; j < 3; j++) next_cycle();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (strb !== S_MEM_SW) begin n_fail++; $display("FAIL midrst_pre_strobes: got %b expected %b", strb, S_MEM_SW); end
        if (retired !== 4'd1) begin n_fail++; $display("FAIL midrst_pre_retired: got %0d expected 1", retired); end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (strb !== S_IDLE) begin n_fail++; $display("FAIL midrst_strobes: got %b expected %b", strb, S_IDLE); end
        if (state !== MEM) begin n_fail++; $display("FAIL midrst_state_hold: got %0d expected %0d", state, MEM); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (state !== FETCH) begin n_fail++; $display("FAIL midrst_state: got %0d expected %0d", state, FETCH); end
        if (retired !== 4'd0) begin n_fail++; $display("FAIL midrst_retired: got %0d expected 0", retired); end
        if (strb !== S_FWAIT) begin n_fail++; $display("FAIL midrst_fetch: got %b expected %b", strb, S_FWAIT); end
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_alu();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_fetch_timeout();
        test_mem_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
